irq_priority_encoder: RTL and testbench



---
 rtl/irq_priority_encoder.sv | 89 ++++++++
 tb/tb_irq_priority_encoder.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/irq_priority_encoder.sv
// Registered 8-to-3 priority encoder. Rising request edges latch into a pending register.
// The highest unmasked pending index is presented with a valid/acknowledge handshake.
module irq_priority_encoder (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] Req,
  input  logic [7:0] Mask,
  input  logic       En,
  input  logic       Ack,
  output logic [2:0] Code,
  output logic       Valid,
  output logic [7:0] Pend
);

  typedef enum logic [0:0] {StIdle, StPresent} state_e;

  state_e     state_q, state_d;
  logic [7:0] req_prev_q;
  logic [7:0] pend_q, pend_d;
  logic [2:0] code_q, code_d;
  logic       valid_q, valid_d;

  logic [7:0] req_event;
  logic [7:0] eligible;
  logic [7:0] clr;
  logic [2:0] top_idx;

  assign req_event = Req & ~req_prev_q;
  assign eligible  = pend_q & ~Mask;

  // Ascending scan so the highest set bit is the last one written.
  always_comb begin
    top_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (eligible[i]) begin
        top_idx = 3'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    valid_d = valid_q;
    clr     = 8'h00;
    unique case (state_q)
      StIdle: begin
        if (En && (eligible != 8'h00)) begin
          state_d = StPresent;
          code_d  = top_idx;
          valid_d = 1'b1;
        end
      end
      StPresent: begin
        if (Ack) begin
          state_d = StIdle;
          valid_d = 1'b0;
          clr     = 8'h01 << code_q;
        end
      end
      default: begin
        state_d = StIdle;
        valid_d = 1'b0;
      end
    endcase
    // A new event on a bit being cleared keeps that bit pending.
    pend_d = (pend_q & ~clr) | req_event;
  end

  always_ff @(posedge Clk) begin
    req_prev_q <= Req;
    if (Reset) begin
      state_q <= StIdle;
      pend_q  <= 8'h00;
      code_q  <= 3'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      code_q  <= code_d;
      valid_q <= valid_d;
    end
  end

  assign Code  = code_q;
  assign Valid = valid_q;
  assign Pend  = pend_q;

endmodule

// File: tb/tb_irq_priority_encoder.sv
// Directed bench for irq_priority_encoder; outputs are sampled 1ns after each rising edge.
module tb_irq_priority_encoder;

  logic       Clk;
  logic       Reset;
  logic [7:0] Req;
  logic [7:0] Mask;
  logic       En;
  logic       Ack;
  logic [2:0] Code;
  logic       Valid;
  logic [7:0] Pend;

  int n_checks;
  int n_fail;
  int grants;

  irq_priority_encoder dut (
    .Clk  (Clk),
    .Reset(Reset),
    .Req  (Req),
    .Mask (Mask),
    .En   (En),
    .Ack  (Ack),
    .Code (Code),
    .Valid(Valid),
    .Pend (Pend)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [2:0] c,
                         input logic [7:0] p);
    chk({tag, ".valid"}, {7'd0, Valid}, {7'd0, v});
    chk({tag, ".code"}, {5'd0, Code}, {5'd0, c});
    chk({tag, ".pend"}, Pend, p);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    Reset = 1'b1; Req = 8'h00; Mask = 8'h00; En = 1'b1; Ack = 1'b0;
    tick(); tick();
    Reset = 1'b0;
    chk_out("reset", 1'b0, 3'd0, 8'h00);

    // Single request
    Req = 8'h20; tick();
    chk_out("single_pend", 1'b0, 3'd0, 8'h20);
    Req = 8'h00; tick();
    chk_out("single_grant", 1'b1, 3'd5, 8'h20);
    Ack = 1'b1; tick();
    chk_out("single_ack", 1'b0, 3'd5, 8'h00);
    Ack = 1'b0;

    // Priority and hold
    Req = 8'h44; tick();
    chk_out("prio_pend", 1'b0, 3'd5, 8'h44);
    tick();
    chk_out("prio_grant6", 1'b1, 3'd6, 8'h44);
    Req = 8'hC4; tick();
    chk_out("prio_hold_a", 1'b1, 3'd6, 8'hC4);
    tick();
    chk_out("prio_hold_b", 1'b1, 3'd6, 8'hC4);
    Ack = 1'b1; tick();
    chk_out("prio_ack6", 1'b0, 3'd6, 8'h84);
    Ack = 1'b0; tick();
    chk_out("prio_grant7", 1'b1, 3'd7, 8'h84);
    Ack = 1'b1; tick();
    chk_out("prio_ack7", 1'b0, 3'd7, 8'h04);
    Ack = 1'b0; tick();
    chk_out("prio_grant2", 1'b1, 3'd2, 8'h04);
    Ack = 1'b1; tick();
    chk_out("prio_ack2", 1'b0, 3'd2, 8'h00);
    Ack = 1'b0; Req = 8'h00; tick();

    // Mask and enable
    Mask = 8'h80; Req = 8'h82; tick();
    chk_out("mask_pend", 1'b0, 3'd2, 8'h82);
    Req = 8'h00; tick();
    chk_out("mask_grant1", 1'b1, 3'd1, 8'h82);
    Ack = 1'b1; tick();
    chk_out("mask_ack1", 1'b0, 3'd1, 8'h80);
    Ack = 1'b0; En = 1'b0; tick(); tick();
    chk_out("en_off", 1'b0, 3'd1, 8'h80);
    Mask = 8'h00; tick();
    chk_out("en_off_unmasked", 1'b0, 3'd1, 8'h80);
    En = 1'b1; tick();
    chk_out("unmask_grant7", 1'b1, 3'd7, 8'h80);
    Ack = 1'b1; tick();
    chk_out("unmask_ack7", 1'b0, 3'd7, 8'h00);
    Ack = 1'b0;

    // Event collides with clear of the same bit
    Req = 8'h08; tick();
    Req = 8'h00; tick();
    chk_out("coll_grant3", 1'b1, 3'd3, 8'h08);
    Ack = 1'b1; Req = 8'h08; tick();
    chk_out("coll_ack", 1'b0, 3'd3, 8'h08);
    Ack = 1'b0; tick();
    chk_out("coll_regrant3", 1'b1, 3'd3, 8'h08);
    Ack = 1'b1; tick();
    chk_out("coll_ack2", 1'b0, 3'd3, 8'h00);
    Ack = 1'b0; Req = 8'h00; tick();

    // Lines high through reset generate no events
    Reset = 1'b1; Req = 8'hFF; tick(); tick();
    Reset = 1'b0; tick(); tick();
    chk_out("rst_held_high", 1'b0, 3'd0, 8'h00);
    Req = 8'h00; tick();

    // Reset while presenting
    Req = 8'h10; tick();
    Req = 8'h00; tick();
    chk_out("pre_reset_grant4", 1'b1, 3'd4, 8'h10);
    Reset = 1'b1; tick();
    chk_out("mid_reset", 1'b0, 3'd0, 8'h00);
    Reset = 1'b0; tick();

    // Level hold gives one event; Ack follows Valid immediately
    grants = 0;
    Req = 8'h01;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (Valid) begin
        grants++;
        chk("level_code", {5'd0, Code}, 8'h00);
      end
      Ack = Valid;
    end
    Req = 8'h00; Ack = 1'b0;
    chk("level_grants", 8'(grants), 8'd1);
    tick();
    chk_out("level_end", 1'b0, 3'd0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
